// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue. It issues sequential word fetches into a memory with a
// fixed one-cycle latency, and buffers the returned words with their PCs in a
// DEPTH-entry FIFO. The head entry goes to decode over a valid/ready handshake.
// A redirect flushes the queue and any in-flight response, then restarts fetch.
// Optional macro IFQ_BYPASS_EN: when the FIFO is empty, a returning word is shown
// straight from imem_rdata to decode in the cycle it arrives.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       IFQ_imem_req,
  output logic [31:0]                IFQ_imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       DU_ready,
  output logic                       IFQ_valid,
  output logic [31:0]                IFQ_Instr,
  output logic [31:0]                IFQ_PC,
  output logic [$clog2(DEPTH):0]     IFQ_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic [CW-1:0] occupancy;
  logic          issue;
  logic          fifo_nonempty;
  logic          bypass;
  logic          push;
  logic          pop;

  // Issue, handshake and push/pop decisions; a redirect suppresses all of them.
  always_comb begin
    // An in-flight word already owns a slot; a pop in this cycle is not credited.
    occupancy     = count_q + CW'(inflight_q);
    issue         = rst_n && !redirect && (occupancy < CW'(DEPTH));
    fifo_nonempty = (count_q != '0);
`ifdef IFQ_BYPASS_EN
    bypass        = !fifo_nonempty && inflight_q && !redirect;
`else
    bypass        = 1'b0;
`endif
    IFQ_valid     = !redirect && (fifo_nonempty || bypass);
    pop           = IFQ_valid && DU_ready && fifo_nonempty;
    // A word taken directly by decode on the bypass path is not stored.
    push          = inflight_q && !redirect && !(bypass && DU_ready);
    IFQ_imem_req  = issue;
    IFQ_imem_addr = pc_q;
    IFQ_count     = count_q;
  end

  // Head entry shown to decode; both fields read as zero when nothing is valid.
  always_comb begin
    IFQ_Instr = '0;
    IFQ_PC    = '0;
    if (fifo_nonempty && !redirect) begin
      IFQ_Instr = instr_mem_q[rd_ptr_q];
      IFQ_PC    = pc_mem_q[rd_ptr_q];
    end
`ifdef IFQ_BYPASS_EN
    else if (bypass) begin
      IFQ_Instr = imem_rdata;
      IFQ_PC    = inflight_pc_q;
    end
`endif
  end

  // Control state: fetch PC, FIFO pointers/count and the in-flight tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect) begin
      pc_q       <= {redirect_pc[31:2], 2'b00};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
      inflight_q <= issue;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents past the count are don't-care, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a queue-based reference model.
// The bench acts as the one-cycle-latency instruction memory.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                  clk;
  logic                  rst_n;
  logic                  IFQ_imem_req;
  logic [31:0]           IFQ_imem_addr;
  logic [31:0]           imem_rdata;
  logic                  redirect;
  logic [31:0]           redirect_pc;
  logic                  DU_ready;
  logic                  IFQ_valid;
  logic [31:0]           IFQ_Instr;
  logic [31:0]           IFQ_PC;
  logic [$clog2(DEPTH):0] IFQ_count;

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IFQ_imem_req  (IFQ_imem_req),
    .IFQ_imem_addr (IFQ_imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .DU_ready      (DU_ready),
    .IFQ_valid     (IFQ_valid),
    .IFQ_Instr     (IFQ_Instr),
    .IFQ_PC        (IFQ_PC),
    .IFQ_count     (IFQ_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: decoded entries in program order plus the fetch pointer.
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_infl_pc;

  int n_checks = 0;
  int n_bad    = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc      = RESET_PC;
    m_infl    = 1'b0;
    m_infl_pc = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(IFQ_valid), 32'd0);
    check_eq({tag, "_instr"}, IFQ_Instr, 32'd0);
    check_eq({tag, "_pc"}, IFQ_PC, 32'd0);
    check_eq({tag, "_count"}, 32'(IFQ_count), 32'd0);
    check_eq({tag, "_req"}, 32'(IFQ_imem_req), 32'd0);
    check_eq({tag, "_addr"}, IFQ_imem_addr, RESET_PC);
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          byp;
    bit          e_valid;
    bit          e_req;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    ent_t        tmp;
    redirect    = rd;
    redirect_pc = rpc;
    DU_ready    = rdy;
    imem_rdata  = m_infl ? mem_word(m_infl_pc) : $urandom;
    #1;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = !rd && (q.size() == 0) && m_infl;
`endif
    e_valid = !rd && ((q.size() != 0) || byp);
    e_req   = !rd && ((q.size() + int'(m_infl)) < DEPTH);
    e_instr = '0;
    e_pc    = '0;
    if (e_valid && q.size() != 0) begin
      e_instr = q[0].instr;
      e_pc    = q[0].pc;
    end else if (e_valid) begin
      e_instr = mem_word(m_infl_pc);
      e_pc    = m_infl_pc;
    end
    check_eq("req", 32'(IFQ_imem_req), 32'(e_req));
    if (e_req) check_eq("addr", IFQ_imem_addr, m_pc);
    check_eq("valid", 32'(IFQ_valid), 32'(e_valid));
    check_eq("instr", IFQ_Instr, e_instr);
    check_eq("head_pc", IFQ_PC, e_pc);
    check_eq("count", 32'(IFQ_count), 32'(q.size()));
    check_eq("count_le_depth", 32'(IFQ_count <= DEPTH), 32'd1);
    @(posedge clk);
    if (rd) begin
      q.delete();
      m_infl = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
    end else begin
      if (q.size() != 0 && rdy) tmp = q.pop_front();
      if (m_infl && !(byp && rdy)) begin
        tmp.pc    = m_infl_pc;
        tmp.instr = mem_word(m_infl_pc);
        q.push_back(tmp);
      end
      if (e_req) begin
        m_infl    = 1'b1;
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    DU_ready    = 1'b0;
    imem_rdata  = '0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming from reset with decode always ready.
    repeat (12) step(1'b0, '0, 1'b1);

    // Back-pressure: queue fills and fetch stalls, then drains in order.
    repeat (10) step(1'b0, '0, 1'b0);
    repeat (8) step(1'b0, '0, 1'b1);

    // Redirect with three queued entries and one in flight; low bits ignored.
    step(1'b1, 32'h0000_0200, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0);
    check_eq("pre_flush_count", 32'(IFQ_count), 32'd3);
    step(1'b1, 32'h0000_0103, 1'b0);
    check_eq("post_flush_count", 32'(IFQ_count), 32'd0);
    check_eq("post_flush_addr", IFQ_imem_addr, 32'h0000_0100);
    repeat (6) step(1'b0, '0, 1'b1);

    // Back-to-back redirects, then fetch across the top of the address space.
    step(1'b1, 32'h0000_4000, 1'b1);
    step(1'b1, 32'hFFFF_FFF0, 1'b1);
    repeat (10) step(1'b0, '0, 1'b1);

    // Random decode stalls with occasional redirects.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 99) < 3), $urandom, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset with a full queue, then restart from RESET_PC.
    repeat (8) step(1'b0, '0, 1'b0);
    check_eq("full_before_reset", 32'(IFQ_count), DEPTH);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(negedge clk);
    redirect = 1'b0;
    DU_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step(1'b0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
